// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word-aligned read per instruction,
// holds the returned word for decode, and supports flush/redirect with
// discard of in-flight responses plus a WAIT-state timeout.
module instr_fetch #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TMO    = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              fetch_en,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_adv,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              err_misalign,
   output logic              err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_e;

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              err_mis_q, err_mis_d;
   logic              err_tmo_q, err_tmo_d;
   logic [7:0]        cnt_q, cnt_d;

   logic aligned;
   logic fetch_ok;
   logic tmo_hit;

   assign aligned  = (pc[1:0] == 2'b00);
   assign fetch_ok = fetch_en && !flush && aligned;
   assign tmo_hit  = (cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state selection; flush outranks every handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (fetch_ok) state_d = S_REQ;
         S_REQ: begin
            if (flush)        state_d = mem_gnt ? S_DROP : S_IDLE;
            else if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A flush coinciding with the beat consumes it, so nothing is left to drop
            if (flush)           state_d = mem_rvalid ? S_IDLE : S_DROP;
            else if (mem_rvalid) state_d = S_HOLD;
            else if (tmo_hit)    state_d = S_DROP;
         end
         S_HOLD: if (flush || instr_ready) state_d = S_IDLE;
         S_DROP: if (mem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      mem_req     = (state_q == S_REQ);
      instr_valid = (state_q == S_HOLD);
      pc_adv      = (state_q == S_HOLD) && instr_ready && !flush && !RESET;
   end

   // Datapath next values: address latch, instruction capture, errors, WAIT counter
   always_comb begin
      mem_addr_d = mem_addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      err_mis_d  = err_mis_q;
      err_tmo_d  = err_tmo_q;
      cnt_d      = '0;
      if (state_q == S_IDLE) begin
         if (fetch_ok) mem_addr_d = pc;
         if (fetch_en && !flush && !aligned) err_mis_d = 1'b1;
      end
      if (state_q == S_WAIT) begin
         cnt_d = cnt_q + 8'd1;
         if (mem_rvalid && !flush) begin
            instr_d    = mem_rdata;
            instr_pc_d = mem_addr_q;
         end
         if (!mem_rvalid && !flush && tmo_hit) err_tmo_d = 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mem_addr_q <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         err_mis_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         err_mis_q  <= err_mis_d;
         err_tmo_q  <= err_tmo_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mem_addr     = mem_addr_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// fetch stream checked against a transaction-level memory/decode model.
module tb_instr_fetch;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned TMO_P = 15;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          fetch_en, flush, mem_gnt, mem_rvalid, instr_ready;
   logic [AW-1:0] pc;
   logic [DW-1:0] mem_rdata;
   logic          pc_adv, mem_req, instr_valid, err_misalign, err_timeout;
   logic [AW-1:0] mem_addr, instr_pc;
   logic [DW-1:0] instr;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .TMO(TMO_P)) dut (
      .CLK(CLK), .RESET(RESET), .fetch_en(fetch_en), .flush(flush), .pc(pc),
      .pc_adv(pc_adv), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   // Memory contents as a pure function of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A51234;
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs;
      fetch_en = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; instr_ready = 0;
   endtask

   // Drive a zero-wait fetch so the DUT sits in HOLD on return
   task automatic fetch_to_hold(input logic [31:0] a, input logic [31:0] d);
      pc = a; fetch_en = 1; mem_gnt = 1;
      tick;
      fetch_en = 0;
      tick;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = d;
      tick;
      mem_rvalid = 0;
   endtask

   task automatic test_reset;
      idle_inputs;
      RESET = 1; pc = 32'h102; fetch_en = 1; flush = 1; mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
      tick; tick;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
      checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL reset_pc_adv: got %0b want 0", pc_adv); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %0b want 0", instr_valid); end
      checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL reset_err_misalign: got %0b want 0", err_misalign); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %0b want 0", err_timeout); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      RESET = 0; idle_inputs; pc = 32'h0;
      tick;
   endtask

   task automatic test_basic;
      pc = 32'h100; fetch_en = 1; mem_gnt = 1;
      tick;
      fetch_en = 0;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %0b want 1", mem_req); end
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL basic_addr: got %h want 100", mem_addr); end
      tick;
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %0b want 0", mem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", instr_valid); end
      tick;
      mem_rvalid = 0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", instr_valid); end
      checks++; if (instr !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_instr: got %h want deadbeef", instr); end
      checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL basic_instr_pc: got %h want 100", instr_pc); end
      checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL basic_adv_idle: got %0b want 0", pc_adv); end
      instr_ready = 1;
      #1;
      checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL basic_adv: got %0b want 1", pc_adv); end
      tick;
      instr_ready = 0;
      #1;
      checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL basic_adv_once: got %0b want 0", pc_adv); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b want 0", instr_valid); end
   endtask

   task automatic test_hold_stall;
      logic [31:0] d;
      d = $urandom();
      fetch_to_hold(32'h200, d);
      fetch_en = 1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, instr_valid); end
         checks++; if (instr !== d) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, d); end
         checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 200", i, instr_pc); end
         checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL stall_adv[%0d]: got %0b want 0", i, pc_adv); end
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %0b want 0", i, mem_req); end
         tick;
      end
      fetch_en = 0; instr_ready = 1;
      #1;
      checks++; if (pc_adv !== 1'b1) begin errors++; $display("FAIL stall_adv_end: got %0b want 1", pc_adv); end
      tick;
      instr_ready = 0;
   endtask

   task automatic test_flush_wait;
      pc = 32'h100; fetch_en = 1; mem_gnt = 1;
      tick;
      fetch_en = 0;
      tick;
      mem_gnt = 0; flush = 1;
      tick;
      flush = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fw_valid_drop: got %0b want 0", instr_valid); end
      tick;
      mem_rvalid = 0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fw_discard: got %0b want 0", instr_valid); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fw_req: got %0b want 0", mem_req); end
      fetch_to_hold(32'h104, 32'hCAFEF00D);
      checks++; if (instr !== 32'hCAFEF00D) begin errors++; $display("FAIL fw_next_instr: got %h want cafef00d", instr); end
      checks++; if (instr_pc !== 32'h104) begin errors++; $display("FAIL fw_next_pc: got %h want 104", instr_pc); end
      instr_ready = 1;
      tick;
      instr_ready = 0;
   endtask

   task automatic test_flush_hold;
      fetch_to_hold(32'h300, 32'h0BADF00D);
      flush = 1; instr_ready = 1;
      #1;
      checks++; if (pc_adv !== 1'b0) begin errors++; $display("FAIL fh_adv: got %0b want 0", pc_adv); end
      tick;
      flush = 0; instr_ready = 0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fh_valid: got %0b want 0", instr_valid); end
      pc = 32'h340; fetch_en = 1; mem_gnt = 0;
      tick;
      fetch_en = 0; flush = 1;
      tick;
      flush = 0;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL freq_req: got %0b want 0", mem_req); end
   endtask

   task automatic test_random;
      logic [31:0] pc_r, resp_addr, exp_instr, exp_pc;
      bit outstanding, live, exp_valid, rv_now, fl, exp_adv;
      int unsigned dly;
      int delivered;
      pc_r = 32'h1000; resp_addr = '0; exp_instr = '0; exp_pc = '0;
      outstanding = 0; live = 0; exp_valid = 0; dly = 0; delivered = 0;
      idle_inputs;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         pc = pc_r;
         fetch_en = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 19) == 0);
         flush = fl;
         instr_ready = 1'($urandom_range(0, 1));
         mem_gnt = 1'($urandom_range(0, 1));
         rv_now = outstanding && (dly == 0);
         mem_rvalid = rv_now;
         mem_rdata = rv_now ? mem_word(resp_addr) : $urandom();
         #1;
         exp_adv = exp_valid && instr_ready && !fl;
         checks++; if (pc_adv !== exp_adv) begin errors++; $display("FAIL rnd_adv @%0d: got %0b want %0b", cyc, pc_adv, exp_adv); end
         checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %0b want %0b", cyc, instr_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (instr !== exp_instr) begin errors++; $display("FAIL rnd_instr @%0d: got %h want %h", cyc, instr, exp_instr); end
            checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL rnd_instr_pc @%0d: got %h want %h", cyc, instr_pc, exp_pc); end
         end
         checks++; if (mem_req && outstanding) begin errors++; $display("FAIL rnd_single @%0d: got mem_req=1 want 0 with request outstanding", cyc); end
         if (mem_req) begin
            checks++; if (mem_addr !== pc_r) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, mem_addr, pc_r); end
         end
         // advance the transaction-level model across this clock edge
         if (exp_valid && (instr_ready || fl)) begin
            exp_valid = 0;
            if (!fl) begin pc_r += 4; delivered++; end
         end
         if (rv_now) begin
            outstanding = 0;
            if (live && !fl) begin exp_valid = 1; exp_instr = mem_word(resp_addr); exp_pc = resp_addr; end
            live = 0;
         end else if (outstanding) begin
            dly--;
         end
         if (mem_req && mem_gnt) begin
            outstanding = 1; live = !fl; resp_addr = pc_r; dly = $urandom_range(0, 3);
         end
         if (fl) begin
            live = 0;
            pc_r = $urandom() & 32'h0000FFFC;
         end
         tick;
      end
      idle_inputs;
      // let any response still owed by the memory model arrive
      if (outstanding) begin
         mem_rvalid = 1; mem_rdata = mem_word(resp_addr);
         tick;
         mem_rvalid = 0;
      end
      instr_ready = 1;
      tick;
      instr_ready = 0;
      checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress: got %0d instructions want >=50", delivered); end
      checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL rnd_mis: got %0b want 0", err_misalign); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rnd_tmo: got %0b want 0", err_timeout); end
   endtask

   task automatic test_misalign;
      pc = 32'h102; fetch_en = 1;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req[%0d]: got %0b want 0", i, mem_req); end
         checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL mis_err[%0d]: got %0b want 1", i, err_misalign); end
      end
      fetch_en = 0;
      tick;
   endtask

   task automatic test_timeout;
      pc = 32'h300; fetch_en = 1; mem_gnt = 1;
      tick;
      fetch_en = 0;
      tick;
      mem_gnt = 0;
      repeat (TMO_P - 1) tick;
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %0b want 0", err_timeout); end
      tick;
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: got %0b want 1", err_timeout); end
      checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL tmo_mis_sticky: got %0b want 1", err_misalign); end
      pc = 32'h400; fetch_en = 1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_drop_req[%0d]: got %0b want 0", i, mem_req); end
         tick;
      end
      fetch_en = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
      tick;
      mem_rvalid = 0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL tmo_discard: got %0b want 0", instr_valid); end
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b want 1", err_timeout); end
   endtask

   task automatic test_reset_wait;
      pc = 32'h500; fetch_en = 1; mem_gnt = 1;
      tick;
      fetch_en = 0;
      tick;
      mem_gnt = 0; RESET = 1;
      tick;
      RESET = 0;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %0b want 0", mem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %0b want 0", instr_valid); end
      checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL rw_mis: got %0b want 0", err_misalign); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rw_tmo: got %0b want 0", err_timeout); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rw_instr: got %h want 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rw_instr_pc: got %h want 0", instr_pc); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rw_addr: got %h want 0", mem_addr); end
      mem_rvalid = 1; mem_rdata = 32'h77778888;
      tick;
      mem_rvalid = 0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_late_valid: got %0b want 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rw_late_instr: got %h want 0", instr); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_hold_stall;
      test_flush_wait;
      test_flush_hold;
      test_random;
      test_misalign;
      test_timeout;
      test_reset_wait;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, width of pc, mem_addr and instr_pc.
  DATA_W, 32, width of mem_rdata and instr.
  TMO, 15, maximum WAIT cycles before fetch timeout (1..255).
REQ-002 Ports SHALL be, one per line:
  CLK  in  1  single clock; all state updates on posedge CLK.
  RESET  in  1  synchronous, active-high reset.
  fetch_en  in  1  enables launching new fetches.
  flush  in  1  redirect; discards the current fetch and the held instruction.
  pc  in  ADDR_W  fetch address from the program counter.
  pc_adv  out  1  one-cycle pulse: instruction consumed, program counter may advance.
  mem_req  out  1  memory read request.
  mem_addr  out  ADDR_W  request address, stable while mem_req=1.
  mem_gnt  in  1  memory accepts the request this cycle.
  mem_rvalid  in  1  read data valid.
  mem_rdata  in  DATA_W  read data.
  instr  out  DATA_W  fetched instruction.
  instr_pc  out  ADDR_W  address of instr.
  instr_valid  out  1  instr is valid for decode.
  instr_ready  in  1  decode accepts instr.
  err_misalign  out  1  sticky: fetch of a non-word-aligned pc attempted.
  err_timeout  out  1  sticky: TMO elapsed in WAIT.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DROP.
REQ-004 IDLE: with fetch_en=1, flush=0 and pc[1:0]=0, the block SHALL latch pc into mem_addr and go to REQ next cycle.
REQ-005 IDLE: with fetch_en=1, flush=0 and pc[1:0]!=0, the block SHALL set err_misalign, issue no request and remain in IDLE.
REQ-006 REQ: mem_req SHALL be 1 and mem_addr SHALL hold the latched pc until mem_gnt=1, then the FSM goes to WAIT.
REQ-007 WAIT: on mem_rvalid=1 the block SHALL capture mem_rdata into instr and mem_addr into instr_pc, set instr_valid=1 and go to HOLD.
REQ-008 Minimum latency SHALL be: mem_gnt in cycle N, mem_rvalid in cycle N+1, instr_valid=1 in cycle N+2.
REQ-009 HOLD: instr, instr_pc and instr_valid SHALL stay stable until instr_ready=1.
REQ-010 HOLD with instr_ready=1: pc_adv SHALL pulse for exactly that cycle, instr_valid SHALL drop the next cycle, and the FSM goes to IDLE.
REQ-011 The block SHALL NOT sample pc from IDLE until the cycle after pc_adv, so the program counter has one cycle to update.
REQ-012 Flush in IDLE or HOLD SHALL clear instr_valid next cycle, suppress pc_adv, and go or stay in IDLE.
REQ-013 Flush in REQ with mem_gnt=0 SHALL deassert mem_req next cycle and go to IDLE.
REQ-014 Flush in REQ with mem_gnt=1, or flush in WAIT, SHALL go to DROP.
REQ-015 DROP SHALL discard the next mem_rvalid beat without touching instr or instr_valid, then go to IDLE.
REQ-016 If flush and mem_rvalid occur together in WAIT, that beat SHALL be discarded and the FSM SHALL go directly to IDLE.
REQ-017 A flush coincident with instr_ready=1 in HOLD SHALL take priority; pc_adv=0.
REQ-018 A WAIT-cycle counter SHALL clear on WAIT entry; when it reaches TMO without mem_rvalid, err_timeout SHALL set and the FSM SHALL go to DROP.
REQ-019 mem_req SHALL be 1 only in REQ, and at most one request SHALL be outstanding.
REQ-020 Errors SHALL be sticky until RESET.

Reset
REQ-021 RESET=1 at posedge CLK SHALL force IDLE, and clear mem_req, pc_adv, instr_valid, err_misalign, err_timeout and the counter, and set instr=0, instr_pc=0 and mem_addr=0.
REQ-022 RESET mid-fetch (REQ, WAIT or DROP) SHALL abandon the transaction; a late mem_rvalid after reset SHALL be ignored in IDLE.
REQ-023 RESET SHALL take priority over flush and every other input.

Verification
REQ-024 pc=0x100, fetch_en=1, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> instr=0xDEADBEEF and instr_pc=0x100 two cycles after gnt; instr_ready=1 -> one pc_adv pulse.
REQ-025 instr_ready held 0 for 5 cycles in HOLD -> instr and instr_valid stable, pc_adv=0, mem_req=0 throughout.
REQ-026 flush in WAIT, then mem_rvalid=1 with 0x12345678 -> instr_valid stays 0, FSM reaches IDLE, next fetch of 0x104 returns its own data.
REQ-027 pc=0x102, fetch_en=1 -> err_misalign=1, mem_req never asserts.
REQ-028 TMO=15, mem_gnt then no mem_rvalid -> err_timeout=1 after 15 WAIT cycles, FSM in DROP; later mem_rvalid discarded.
REQ-029 RESET=1 while in WAIT -> all outputs are at reset values next cycle, and a late mem_rvalid does not set instr_valid.
